// File: rtl/hft_pkg.sv
// Shared types and helpers for the trading datapath: vote FSM states,
// conflict counter width and a population count over algorithm flags.
package hft_pkg;

  typedef enum logic [1:0] {StIdle, StArmed, StCooldown} vote_state_e;

  localparam int unsigned CONFLICT_W = 8;
  localparam int unsigned MAX_ALG    = 32;

  // Callers zero-extend their flag vector to MAX_ALG bits.
  function automatic logic [7:0] popcount(input logic [MAX_ALG-1:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < MAX_ALG; i++) begin
      n = n + 8'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/show_debounce.sv
// Push-button conditioner: 2-flop synchroniser, DB_CYCLES stability filter and
// a strobe that is high in the cycle before show_db rises.
module show_debounce #(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic show,
  output logic show_db,
  output logic show_rise
);

  localparam int unsigned DCW = $clog2(DB_CYCLES + 1);
  localparam logic [DCW-1:0] LastCnt = DCW'(DB_CYCLES - 1);

  logic           sync1_q, sync2_q;
  logic           db_q, db_d;
  logic [DCW-1:0] cnt_q, cnt_d;

  // Any cycle where the input agrees with show_db restarts the count.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == LastCnt) begin
        db_d = ~db_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= show;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign show_db   = db_q;
  assign show_rise = db_d & ~db_q;

endmodule

// File: rtl/trade_vote_aggregator.sv
// K-of-N buy/sell voter with conflict counting, post-trade cooldown and a
// debounced snapshot of sticky trade flags and profit for the display.
module trade_vote_aggregator
  import hft_pkg::*;
#(
  parameter int unsigned N_ALG     = 3,
  parameter int unsigned VOTE_K    = 2,
  parameter int unsigned PW        = 16,
  parameter int unsigned COOLDOWN  = 4,
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [N_ALG-1:0]             alg_buy,
  input  logic [N_ALG-1:0]             alg_sell,
  input  logic [PW-1:0]                profit_in,
  input  logic                         show,
  output logic                         buy_pulse,
  output logic                         sell_pulse,
  output logic [$clog2(N_ALG+1)-1:0]   buy_votes,
  output logic [$clog2(N_ALG+1)-1:0]   sell_votes,
  output logic                         busy,
  output logic [CONFLICT_W-1:0]        conflict_cnt,
  output logic                         buy_disp,
  output logic                         sell_disp,
  output logic [PW-1:0]                profit_disp
);

  localparam int unsigned VW = $clog2(N_ALG + 1);
  localparam int unsigned CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [VW-1:0] KVotes = VW'(VOTE_K);

  if (VOTE_K < 1 || VOTE_K > N_ALG || N_ALG > MAX_ALG) begin : g_bad_params
    $error("trade_vote_aggregator: VOTE_K must be in 1..N_ALG and N_ALG <= MAX_ALG");
  end

  vote_state_e           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [VW-1:0]         buy_votes_q, sell_votes_q;
  logic                  buy_pulse_q, buy_pulse_d, sell_pulse_q, sell_pulse_d;
  logic [CONFLICT_W-1:0] conflict_q, conflict_d;
  logic                  stk_buy_q, stk_sell_q;
  logic                  buy_disp_q, sell_disp_q;
  logic [PW-1:0]         profit_disp_q;
  logic                  buy_hit, sell_hit, conflict;
  logic                  show_db, snap;

  show_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_show_debounce (
    .clk      (clk),
    .rst      (rst),
    .show     (show),
    .show_db  (show_db),
    .show_rise(snap)
  );

  assign buy_hit  = buy_votes_q >= KVotes;
  assign sell_hit = sell_votes_q >= KVotes;
  assign conflict = buy_hit & sell_hit;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    buy_pulse_d  = 1'b0;
    sell_pulse_d = 1'b0;
    conflict_d   = conflict_q;

    // Conflicts are tallied even while disabled, but not while cooling down.
    if (conflict && state_q != StCooldown && conflict_q != '1) begin
      conflict_d = conflict_q + 1'b1;
    end

    if (!enable) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StArmed;
          cnt_d   = '0;
        end
        StArmed: begin
          if (buy_hit ^ sell_hit) begin
            buy_pulse_d  = buy_hit;
            sell_pulse_d = sell_hit;
            if (COOLDOWN > 0) begin
              state_d = StCooldown;
              cnt_d   = CW'(COOLDOWN);
            end
          end
        end
        StCooldown: begin
          if (cnt_q == CW'(1) || cnt_q == '0) begin
            state_d = StArmed;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      buy_votes_q   <= '0;
      sell_votes_q  <= '0;
      buy_pulse_q   <= 1'b0;
      sell_pulse_q  <= 1'b0;
      conflict_q    <= '0;
      stk_buy_q     <= 1'b0;
      stk_sell_q    <= 1'b0;
      buy_disp_q    <= 1'b0;
      sell_disp_q   <= 1'b0;
      profit_disp_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      buy_votes_q  <= VW'(popcount(MAX_ALG'(alg_buy)));
      sell_votes_q <= VW'(popcount(MAX_ALG'(alg_sell)));
      buy_pulse_q  <= buy_pulse_d;
      sell_pulse_q <= sell_pulse_d;
      conflict_q   <= conflict_d;
      // A pulse coincident with the snapshot is shown and not carried over.
      if (snap) begin
        buy_disp_q    <= stk_buy_q | buy_pulse_q;
        sell_disp_q   <= stk_sell_q | sell_pulse_q;
        profit_disp_q <= profit_in;
        stk_buy_q     <= 1'b0;
        stk_sell_q    <= 1'b0;
      end else begin
        stk_buy_q  <= stk_buy_q | buy_pulse_q;
        stk_sell_q <= stk_sell_q | sell_pulse_q;
      end
    end
  end

  assign buy_pulse    = buy_pulse_q;
  assign sell_pulse   = sell_pulse_q;
  assign buy_votes    = buy_votes_q;
  assign sell_votes   = sell_votes_q;
  assign busy         = (state_q == StCooldown);
  assign conflict_cnt = conflict_q;
  assign buy_disp     = buy_disp_q;
  assign sell_disp    = sell_disp_q;
  assign profit_disp  = profit_disp_q;

endmodule
